// File: rtl/wb_param_cntr_if.sv
// wb_param_cntr_if: Wishbone slave bus bundle for wb_param_cntr.
interface wb_param_cntr_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_param_cntr.sv
// wb_param_cntr: Wishbone-programmable up/down counter with wrap/saturate,
// reload, compare match, sticky status and a level interrupt.
// Optional 8-bit tick prescaler: define WB_PARAM_CNTR_PRESCALER_EN.
module wb_param_cntr #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned OUT_BITS = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   wb_param_cntr_if.slave      bus,
   output logic [OUT_BITS-1:0] cnt_o,
   output logic [OUT_BITS-1:0] cnt_oeb_o,
   output logic                irq_o
);
   localparam int unsigned    BUS_W  = 32;
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [2:0]     A_CTRL = 3'd0;
   localparam logic [2:0]     A_LOAD = 3'd1;
   localparam logic [2:0]     A_CMP  = 3'd2;
   localparam logic [2:0]     A_CNT  = 3'd3;
   localparam logic [2:0]     A_STAT = 3'd4;

   // byte-lane merge of write data over an existing register image
   function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old,
                                                   input logic [BUS_W-1:0] wdat,
                                                   input logic [3:0]       be);
      logic [BUS_W-1:0] res;
      for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wdat[8*b +: 8] : old[8*b +: 8];
      return res;
   endfunction

   logic             en_q, dir_q, mode_q, irq_en_q;
   logic             en_d, dir_d, mode_d, irq_en_d;
   logic [WIDTH-1:0] load_q, cmp_q, count_q;
   logic [WIDTH-1:0] load_d, cmp_d, count_d;
   logic             match_q, ovf_q, irq_q, ack_q;
   logic             match_d, ovf_d, irq_d, ack_d;
   logic [BUS_W-1:0] dat_q, dat_d, rd_word;
   logic             match_set, ovf_set;
   logic [7:0]       pre_rd;

   logic       req, wr;
   logic [2:0] idx;
   logic       load_stb, w1c_match, w1c_ovf, tick, at_term;
   logic       unused_bits;

   assign req       = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack_q;
   assign wr        = req & bus.wbs_we_i;
   assign idx       = bus.wbs_adr_i[4:2];
   assign load_stb  = wr & (idx == A_CTRL) & bus.wbs_sel_i[0] & bus.wbs_dat_i[4];
   assign w1c_match = wr & (idx == A_STAT) & bus.wbs_sel_i[0] & bus.wbs_dat_i[0];
   assign w1c_ovf   = wr & (idx == A_STAT) & bus.wbs_sel_i[0] & bus.wbs_dat_i[1];
   assign at_term   = dir_q ? (count_q == '0) : (count_q == ONES);
   assign unused_bits = ^{bus.wbs_adr_i[31:5], bus.wbs_adr_i[1:0]};

`ifdef WB_PARAM_CNTR_PRESCALER_EN
   logic [7:0] pre_q, pre_d, psc_q, psc_d;
   assign tick   = en_q & (psc_q == pre_q);
   assign pre_rd = pre_q;

   // prescaler: cleared while disabled or on reload, restarts after each tick
   always_comb begin
      psc_d = psc_q + 8'd1;
      if (!en_q || load_stb || (psc_q == pre_q)) psc_d = 8'd0;
   end
`else
   assign tick   = en_q;
   assign pre_rd = 8'h00;
`endif

   // register read mux
   always_comb begin
      rd_word = '0;
      case (idx)
         A_CTRL:  rd_word = {16'h0, pre_rd, 4'h0, irq_en_q, mode_q, dir_q, en_q};
         A_LOAD:  rd_word = BUS_W'(load_q);
         A_CMP:   rd_word = BUS_W'(cmp_q);
         A_CNT:   rd_word = BUS_W'(count_q);
         A_STAT:  rd_word = {30'h0, ovf_q, match_q};
         default: rd_word = '0;
      endcase
   end

   // next-state: register writes, counter step, sticky status, bus response
   always_comb begin
      en_d      = en_q;
      dir_d     = dir_q;
      mode_d    = mode_q;
      irq_en_d  = irq_en_q;
      load_d    = load_q;
      cmp_d     = cmp_q;
      count_d   = count_q;
      match_set = 1'b0;
      ovf_set   = 1'b0;
`ifdef WB_PARAM_CNTR_PRESCALER_EN
      pre_d     = pre_q;
`endif

      if (wr) begin
         case (idx)
            A_CTRL: begin
               if (bus.wbs_sel_i[0]) {irq_en_d, mode_d, dir_d, en_d} = bus.wbs_dat_i[3:0];
`ifdef WB_PARAM_CNTR_PRESCALER_EN
               if (bus.wbs_sel_i[1]) pre_d = bus.wbs_dat_i[15:8];
`endif
            end
            A_LOAD:  load_d = WIDTH'(byte_merge(BUS_W'(load_q), bus.wbs_dat_i, bus.wbs_sel_i));
            A_CMP:   cmp_d  = WIDTH'(byte_merge(BUS_W'(cmp_q), bus.wbs_dat_i, bus.wbs_sel_i));
            default: ;
         endcase
      end

      // reload strobe uses the pre-write LOAD and beats a same-cycle tick
      if (load_stb) begin
         count_d = load_q;
      end else if (tick) begin
         if (at_term) begin
            ovf_set = 1'b1;
            if (!mode_q) count_d = load_q;
         end else if (dir_q) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            count_d = count_q + WIDTH'(1);
         end
         match_set = (count_d == cmp_q);
      end

      match_d = match_set | (match_q & ~w1c_match);
      ovf_d   = ovf_set | (ovf_q & ~w1c_ovf);
      irq_d   = irq_en_d & (match_d | ovf_d);
      ack_d   = req;
      dat_d   = (req & ~bus.wbs_we_i) ? rd_word : '0;
   end

   // state registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         en_q     <= 1'b0;
         dir_q    <= 1'b0;
         mode_q   <= 1'b0;
         irq_en_q <= 1'b0;
         load_q   <= '0;
         cmp_q    <= ONES;
         count_q  <= '0;
         match_q  <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
`ifdef WB_PARAM_CNTR_PRESCALER_EN
         pre_q    <= 8'd0;
         psc_q    <= 8'd0;
`endif
      end else begin
         en_q     <= en_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
         irq_en_q <= irq_en_d;
         load_q   <= load_d;
         cmp_q    <= cmp_d;
         count_q  <= count_d;
         match_q  <= match_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
`ifdef WB_PARAM_CNTR_PRESCALER_EN
         pre_q    <= pre_d;
         psc_q    <= psc_d;
`endif
      end
   end

   assign bus.wbs_ack_o = ack_q;
   assign bus.wbs_dat_o = dat_q;
   assign cnt_o         = count_q[OUT_BITS-1:0];
   assign cnt_oeb_o     = '0;
   assign irq_o         = irq_q;
endmodule

// File: tb/tb_wb_param_cntr.sv
// tb_wb_param_cntr: directed + random checks of wb_param_cntr against a
// behavioural register-map model (WIDTH=32, OUT_BITS=4).
module tb_wb_param_cntr;
   localparam int unsigned W  = 32;
   localparam int unsigned OB = 4;
   localparam longint unsigned MASK = (64'd1 << W) - 64'd1;
`ifdef WB_PARAM_CNTR_PRESCALER_EN
   localparam bit PRE_EN = 1'b1;
`else
   localparam bit PRE_EN = 1'b0;
`endif

   logic          clk, rst_n;
   logic [OB-1:0] cnt, cnt_oeb;
   logic          irq;
   int            n_cmp = 0;
   int            n_bad = 0;

   wb_param_cntr_if bus();

   wb_param_cntr #(.WIDTH(W), .OUT_BITS(OB)) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .bus      (bus),
      .cnt_o    (cnt),
      .cnt_oeb_o(cnt_oeb),
      .irq_o    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic            m_en, m_dir, m_mode, m_ien, m_match, m_ovf, m_irq, m_ack;
   logic [7:0]      m_pre, m_psc;
   longint unsigned m_load, m_cmp, m_count;
   logic [31:0]     m_dat;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model_blk
      logic            req, we, ld, tick, set_m, set_o, clr_m, clr_o;
      logic [31:0]     rd, d;
      logic [3:0]      be;
      longint unsigned nxt;
      int              idx;
      if (!rst_n) begin
         {m_en, m_dir, m_mode, m_ien, m_match, m_ovf, m_irq, m_ack} = '0;
         m_pre = 8'd0; m_psc = 8'd0;
         m_load = 0; m_cmp = MASK; m_count = 0; m_dat = 32'h0;
      end else begin
         idx  = int'(bus.wbs_adr_i[4:2]);
         d    = bus.wbs_dat_i;
         be   = bus.wbs_sel_i;
         req  = bus.wbs_stb_i && bus.wbs_cyc_i && !m_ack;
         we   = req && bus.wbs_we_i;
         case (idx)
            0:       rd = {16'h0, (PRE_EN ? m_pre : 8'h0), 4'h0, m_ien, m_mode, m_dir, m_en};
            1:       rd = 32'(m_load);
            2:       rd = 32'(m_cmp);
            3:       rd = 32'(m_count);
            4:       rd = {30'h0, m_ovf, m_match};
            default: rd = 32'h0;
         endcase
         ld    = we && idx == 0 && be[0] && d[4];
         clr_m = we && idx == 4 && be[0] && d[0];
         clr_o = we && idx == 4 && be[0] && d[1];
         tick  = m_en && (!PRE_EN || m_psc == m_pre);
         nxt = m_count; set_m = 1'b0; set_o = 1'b0;
         if (ld) nxt = m_load;
         else if (tick) begin
            if (m_dir ? (m_count == 0) : (m_count == MASK)) begin
               set_o = 1'b1;
               nxt   = m_mode ? m_count : m_load;
            end else begin
               nxt = m_dir ? ((m_count + MASK) & MASK) : ((m_count + 1) & MASK);
            end
            set_m = (nxt == m_cmp);
         end
         if (!PRE_EN || !m_en || ld || m_psc == m_pre) m_psc = 8'd0;
         else m_psc = m_psc + 8'd1;
         if (we) begin
            if (idx == 0 && be[0]) {m_ien, m_mode, m_dir, m_en} = d[3:0];
            if (idx == 0 && be[1] && PRE_EN) m_pre = d[15:8];
            if (idx == 1) m_load = 64'(merge(32'(m_load), d, be)) & MASK;
            if (idx == 2) m_cmp  = 64'(merge(32'(m_cmp), d, be)) & MASK;
         end
         m_count = nxt;
         m_match = set_m || (m_match && !clr_m);
         m_ovf   = set_o || (m_ovf && !clr_o);
         m_irq   = m_ien && (m_match || m_ovf);
         m_ack   = req;
         m_dat   = (req && !bus.wbs_we_i) ? rd : 32'h0;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("ack", 32'(bus.wbs_ack_o), 32'(m_ack));
      chk("dat_o", bus.wbs_dat_o, m_dat);
      chk("irq", 32'(irq), 32'(m_irq));
      chk("cnt_o", 32'(cnt), 32'(m_count[OB-1:0]));
      chk("cnt_oeb", 32'(cnt_oeb), 32'h0);
   endtask

   task automatic wb(input logic we, input logic [2:0] idx, input logic [3:0] sel,
                     input logic [31:0] d, output logic [31:0] r);
      logic [31:0] rnd;
      rnd = $urandom();
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_sel_i = sel;  bus.wbs_dat_i = d;
      bus.wbs_adr_i = {rnd[31:5], idx, rnd[1:0]};
      step();
      r = bus.wbs_dat_o;
      chk("ack_one_cycle_after_stb", 32'(bus.wbs_ack_o), 32'h1);
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      step();
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d);
      logic [31:0] r;
      wb(1'b1, idx, 4'hF, d, r);
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
      logic [31:0] r;
      wb(1'b0, idx, 4'hF, $urandom(), r);
      chk(tag, r, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r;
      rst_n = 1'b0;
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // reset values
      rd_chk("rst_ctrl", 3'd0, 32'h0);
      rd_chk("rst_load", 3'd1, 32'h0);
      rd_chk("rst_cmp", 3'd2, 32'hFFFF_FFFF);
      rd_chk("rst_count", 3'd3, 32'h0);
      rd_chk("rst_status", 3'd4, 32'h0);
      rd_chk("rst_reg7", 3'd7, 32'h0);

      // up wrap through the terminal value
      wr(3'd1, 32'hFFFF_FFFE);
      wr(3'd0, 32'h10);
      wr(3'd1, 32'd5);
      wr(3'd0, 32'h01);
      chk("wrap_pre_term", 32'(cnt), 32'hF);
      step();
      chk("wrap_reload", 32'(cnt), 32'h5);
      wr(3'd0, 32'h00);
      rd_chk("wrap_count", 3'd3, 32'd6);
      rd_chk("wrap_status", 3'd4, 32'h3);
      wr(3'd4, 32'h3);
      rd_chk("status_cleared", 3'd4, 32'h0);

      // down saturate with interrupt
      wr(3'd1, 32'd3);
      wr(3'd0, 32'h10);
      wr(3'd0, 32'h0F);
      chk("down_2", 32'(cnt), 32'h2);
      step(); step();
      chk("down_0", 32'(cnt), 32'h0);
      chk("down_irq_low", 32'(irq), 32'h0);
      step();
      chk("sat_hold", 32'(cnt), 32'h0);
      chk("sat_irq", 32'(irq), 32'h1);
      wr(3'd4, 32'h2);
      rd_chk("ovf_reset_after_w1c", 3'd4, 32'h2);
      wr(3'd0, 32'h08);
      wr(3'd4, 32'h2);
      rd_chk("ovf_cleared", 3'd4, 32'h0);
      chk("irq_cleared", 32'(irq), 32'h0);
      wr(3'd0, 32'h00);

      // compare match
      wr(3'd2, 32'd10);
      wr(3'd1, 32'd0);
      wr(3'd0, 32'h10);
      wr(3'd0, 32'h01);
      repeat (8) step();
      chk("cmp_cnt9", 32'(cnt), 32'h9);
      step();
      chk("cmp_cntA", 32'(cnt), 32'hA);
      wr(3'd0, 32'h00);
      rd_chk("cmp_match", 3'd4, 32'h1);
      wr(3'd4, 32'h1);

      // load strobe colliding with a tick
      wr(3'd1, 32'h64);
      wr(3'd0, 32'h01);
      wr(3'd0, 32'h11);
      chk("collide_load", 32'(cnt), 32'h5);
      wr(3'd0, 32'h00);
      rd_chk("collide_count", 3'd3, 32'h66);

      // W1C in the same cycle MATCH sets
      wr(3'd2, 32'h70);
      wr(3'd1, 32'h6E);
      wr(3'd0, 32'h10);
      wr(3'd0, 32'h01);
      wr(3'd4, 32'h1);
      wr(3'd0, 32'h00);
      rd_chk("w1c_collide", 3'd4, 32'h1);
      wr(3'd4, 32'h3);

      // byte enables and ignored writes
      wb(1'b1, 3'd1, 4'b0010, 32'hAABB_CCDD, r);
      rd_chk("sel_load", 3'd1, 32'h0000_CC6E);
      wr(3'd3, 32'h1234);
      rd_chk("count_ro", 3'd3, 32'h72);
      wr(3'd5, 32'hFFFF_FFFF);
      rd_chk("reg5_zero", 3'd5, 32'h0);
      wb(1'b1, 3'd0, 4'b1110, 32'h0000_00FF, r);
      rd_chk("ctrl_sel", 3'd0, 32'h0);

      // prescaler field
      wr(3'd1, 32'd0);
      wr(3'd0, 32'h10);
      wr(3'd0, 32'h0301);
`ifdef WB_PARAM_CNTR_PRESCALER_EN
      chk("psc_0a", 32'(cnt), 32'h0);
      step(); step();
      chk("psc_0b", 32'(cnt), 32'h0);
      step();
      chk("psc_1", 32'(cnt), 32'h1);
      repeat (4) step();
      chk("psc_2", 32'(cnt), 32'h2);
      rd_chk("psc_ctrl", 3'd0, 32'h0301);
`else
      chk("nopsc_1", 32'(cnt), 32'h1);
      step();
      chk("nopsc_2", 32'(cnt), 32'h2);
      rd_chk("nopsc_ctrl", 3'd0, 32'h0001);
`endif
      wr(3'd0, 32'h00);

      // reset in the middle of an access: no ack, state cleared
      wr(3'd0, 32'h01);
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h4; bus.wbs_dat_i = 32'h55;
      #2 rst_n = 1'b0;
      step();
      chk("abort_no_ack", 32'(bus.wbs_ack_o), 32'h0);
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      rd_chk("abort_ctrl", 3'd0, 32'h0);
      rd_chk("abort_load", 3'd1, 32'h0);
      rd_chk("abort_cmp", 3'd2, 32'hFFFF_FFFF);

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         logic [31:0] d, rnd;
         logic [2:0]  idx;
         logic        we;
         d   = $urandom();
         rnd = $urandom();
         idx = 3'($urandom_range(0, 7));
         we  = 1'($urandom_range(0, 1));
         if (idx == 3'd0) begin
            d[0]     = ($urandom_range(0, 3) != 0);
            d[4]     = ($urandom_range(0, 5) == 0);
            d[15:8]  = ($urandom_range(0, 9) == 0) ? 8'hFE : 8'($urandom_range(0, 3));
         end else if (idx == 3'd1 || idx == 3'd2) begin
            d = rnd[0] ? {28'hFFF_FFFF, d[3:0]} : {28'h0, d[3:0]};
         end
         if (rnd[8:6] == 3'd0) begin
            bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
            bus.wbs_sel_i = 4'(rnd[15:12]); bus.wbs_dat_i = d;
            bus.wbs_adr_i = {rnd[31:16], 11'h0, idx, 2'b00};
            repeat (4) step();
            bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
            step();
         end else begin
            wb(we, idx, 4'(rnd[15:12]), d, r);
         end
         repeat ($urandom_range(0, 3)) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
